// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, requests to send, then
// shifts one framed command byte out on device clock falling edges and checks the ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_s,
    input  logic       ps2_dat_s,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_IDLE = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERR       = 3'd6
    } state_t;

    state_t      state_r;
    logic [10:0] shreg_r;
    logic [3:0]  bitcnt_r;
    logic [IW-1:0] inh_cnt_r;
    logic [TW-1:0] tout_cnt_r;
    logic        prev_clk_r;
    logic        fall_s;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    assign fall_s = prev_clk_r & ~ps2_clk_s;

    // Transfer sequencer with registered line drivers and status pulses.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_r    <= ST_IDLE;
            shreg_r    <= 11'd0;
            bitcnt_r   <= 4'd0;
            inh_cnt_r  <= '0;
            tout_cnt_r <= '0;
            prev_clk_r <= 1'b1;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
        end else begin
            prev_clk_r <= ps2_clk_s;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    busy       <= 1'b0;
                    if (tx_start) begin
                        state_r    <= ST_INHIBIT;
                        shreg_r    <= {1'b1, odd_parity(tx_data), tx_data, 1'b0};
                        bitcnt_r   <= 4'd0;
                        inh_cnt_r  <= '0;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                    end
                end
                ST_INHIBIT: begin
                    if (inh_cnt_r == IW'(INHIBIT_CYCLES - 1)) begin
                        state_r    <= ST_REQ;
                        ps2_dat_oe <= 1'b1;
                    end else begin
                        inh_cnt_r <= inh_cnt_r + 1'b1;
                    end
                end
                ST_REQ: begin
                    state_r    <= ST_SEND;
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= ~shreg_r[0];
                    tout_cnt_r <= '0;
                end
                ST_SEND: begin
                    if (fall_s) begin
                        tout_cnt_r <= '0;
                        if (bitcnt_r == 4'd10) begin
                            // Eleventh fall: the device must be holding DAT low as ACK.
                            ps2_dat_oe <= 1'b0;
                            if (!ps2_dat_s) begin
                                state_r <= ST_WAIT_IDLE;
                            end else begin
                                state_r  <= ST_ERR;
                                busy     <= 1'b0;
                                tx_error <= 1'b1;
                            end
                        end else begin
                            shreg_r    <= {1'b1, shreg_r[10:1]};
                            ps2_dat_oe <= ~shreg_r[1];
                            bitcnt_r   <= bitcnt_r + 4'd1;
                        end
                    end else if (tout_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_r    <= ST_ERR;
                        ps2_dat_oe <= 1'b0;
                        busy       <= 1'b0;
                        tx_error   <= 1'b1;
                    end else begin
                        tout_cnt_r <= tout_cnt_r + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    if (ps2_clk_s && ps2_dat_s) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        tx_done <= 1'b1;
                    end else if (tout_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_r  <= ST_ERR;
                        busy     <= 1'b0;
                        tx_error <= 1'b1;
                    end else begin
                        tout_cnt_r <= tout_cnt_r + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                ST_ERR: begin
                    state_r    <= ST_IDLE;
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard using the PS/2 request-to-send sequence. It sits alongside the existing PS/2 receive path and shares the same synchronized PS2_CLK/PS2_DAT lines. Pad drivers are open-drain: the top level drives a line to 0 when its `_oe` output is 1 and tri-states it otherwise.

Parameters:
- INHIBIT_CYCLES, 5000, CLOCK_50 cycles the host holds PS2_CLK low before requesting to send (100 us).
- TIMEOUT_CYCLES, 750000, maximum cycles allowed between device clock falling edges, and while waiting for bus idle, before aborting (15 ms).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- Resetn  in  1  synchronous, active-low reset.
- tx_data  in  8  byte to send; latched when tx_start is accepted.
- tx_start  in  1  one-cycle request; honoured only when busy=0.
- ps2_clk_s  in  1  PS2_CLK after the two-flop synchronizer.
- ps2_dat_s  in  1  PS2_DAT after the two-flop synchronizer.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low.
- busy  out  1  high from acceptance until DONE/ERR exits.
- tx_done  out  1  one-cycle pulse on successful, acknowledged transfer.
- tx_error  out  1  one-cycle pulse on NACK or timeout.

Behaviour:
- Reset (Resetn=0 at posedge):
  - state=IDLE; all outputs 0; internal prev_clk=1; counters 0.
  - Reset mid-transfer releases both lines at the next edge. No done or error pulse is generated.
- Falling edge detection:
  - fall = prev_clk & ~ps2_clk_s; prev_clk updates every cycle.
  - fall is acted on only in SEND and WAIT_IDLE is not edge-driven.
- Frame register:
  - On acceptance, shreg[10:0] = {1'b1 stop, ~^tx_data odd parity, tx_data, 1'b0 start}.
  - bitcnt=0.
- IDLE:
  - All outputs 0.
  - tx_start=1 → INHIBIT next cycle; latch frame; busy=1 from that cycle.
- INHIBIT:
  - clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles, then → REQ.
- REQ:
  - One cycle with clk_oe=1, dat_oe=1 (start bit asserted), then → SEND.
- SEND:
  - clk_oe=0; dat_oe = ~shreg[0].
  - On each fall: shreg shifts right (fill 1), bitcnt++.
  - Falls 1–8 present data bits LSB first; fall 9 presents parity; fall 10 presents stop (line released).
  - On fall 11, sample ps2_dat_s:
    - 0 → ACK, go to WAIT_IDLE.
    - 1 → ERR.
- WAIT_IDLE:
  - Both oe=0.
  - When ps2_clk_s=1 and ps2_dat_s=1 → DONE.
- DONE:
  - tx_done=1 for one cycle, busy=0 in the same cycle → IDLE.
- ERR:
  - Both oe=0; tx_error=1 for one cycle; busy=0 → IDLE.
- Timeout:
  - A counter clears on entering SEND, on every fall, and on entering WAIT_IDLE.
  - It increments otherwise in SEND/WAIT_IDLE. Reaching TIMEOUT_CYCLES → ERR.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- tx_start while busy=1 is ignored; it is not queued. tx_data changes during a transfer have no effect.
- tx_start in the DONE/ERR cycle is ignored; it is accepted from IDLE only.
- Falls arriving in INHIBIT/REQ (device contention) are ignored.
- ps2_clk_oe and ps2_dat_oe are never both 0 in REQ and never both 1 in SEND.
- Latency, tx_start to first clk_oe=1: 1 cycle. REQ begins INHIBIT_CYCLES+1 cycles after acceptance.

Test Plan:
- Bench uses INHIBIT_CYCLES=10, TIMEOUT_CYCLES=2000, and a device model generating a 10 kHz clock with ACK. Send 0xED → dat_oe pattern sampled at device rising edges is start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop released; tx_done pulses once; busy falls the same cycle.
- Send 0xF4 → parity bit 0 (dat_oe=1 during parity); clk_oe high for exactly 10 cycles and REQ 1 cycle before clock release.
- Device model returns no ACK (DAT high at fall 11) → tx_error 1-cycle pulse, tx_done stays 0, state returns to IDLE with both oe=0.
- Device stops clocking after 4 bits → tx_error asserted 2000 cycles after the last fall; both lines released.
- tx_start pulsed with 0x00 mid-transfer of 0xFF → 0xFF frame completes unaltered (parity 1); no second transfer starts.
- Resetn=0 during SEND at bit 5 → next edge clk_oe=dat_oe=busy=0 and no done/error pulse; a new 0xF4 transfer afterwards completes normally.
